// File: rtl/reg_wr_sched.sv
// Round-robin write-port scheduler: two valid/ready producers share one registered register-bank write port.
// Optional same-address merge in IDLE is compiled in with `define REG_WR_SCHED_MERGE_EN.
module reg_wr_sched #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_lock,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_lock,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_data,
  input  logic             rf_stall,
  output logic             wen,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] wdata,
  output logic [1:0]       owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t           state_q;
  logic             prio_q;
  logic             wen_q;
  logic [AW-1:0]    waddr_q;
  logic [WIDTH-1:0] wdata_q;

  logic             grant_a;
  logic             grant_b;
  logic [AW-1:0]    waddr_d;
  logic [WIDTH-1:0] wdata_d;

  // Grants double as the ready outputs, so a ready never appears without its valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !rf_stall) begin
      case (state_q)
        IDLE: begin
          if (a_valid && b_valid) begin
`ifdef REG_WR_SCHED_MERGE_EN
            if (!a_lock && !b_lock && (a_addr == b_addr)) begin
              grant_a = 1'b1;
              grant_b = 1'b1;
            end else
`endif
            if (prio_q) grant_b = 1'b1;
            else        grant_a = 1'b1;
          end else begin
            grant_a = a_valid;
            grant_b = b_valid;
          end
        end
        OWN_A:   grant_a = a_valid;
        OWN_B:   grant_b = b_valid;
        default: ;
      endcase
    end
  end

  // B wins the mux so a merged beat writes B's (later) value.
  always_comb begin
    waddr_d = a_addr;
    wdata_d = a_data;
    if (grant_b) begin
      waddr_d = b_addr;
      wdata_d = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= grant_a | grant_b;
      if (grant_a || grant_b) begin
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
      end
      if (grant_a && grant_b) begin
        state_q <= IDLE;
        prio_q  <= 1'b0;
      end else if (grant_a) begin
        state_q <= a_lock ? OWN_A : IDLE;
        prio_q  <= 1'b1;
      end else if (grant_b) begin
        state_q <= b_lock ? OWN_B : IDLE;
        prio_q  <= 1'b0;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign wen     = wen_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign owner   = state_q;

endmodule
